// File: rtl/bp_be_fe_queue_fifo_pkg.sv
// Shared sizing and packet layout for the speculative BE FE queue buffer.
// Packet layout mirrors the core-if FE queue packet.
package bp_be_fe_queue_fifo_pkg;

  typedef struct packed {
    logic [1:0]  msg_type;
    logic [38:0] pc;
    logic [31:0] instr;
    logic [9:0]  branch_metadata;
  } bp_fe_queue_s;

  localparam int fe_queue_width_lp     = $bits(bp_fe_queue_s);
  localparam int bp_be_fe_queue_els_gp = 8;

endpackage

// File: rtl/bp_be_fe_queue_fifo_chk.sv
// Protocol checks for the FE queue buffer: commit and yumi legality.
module bp_be_fe_queue_fifo_chk #(
  parameter int ptr_width_p = 4
) (
  input logic                   clk_i,
  input logic                   reset_i,
  input logic                   commit_v_i,
  input logic                   clr_v_i,
  input logic                   yumi_i,
  input logic                   v_o_i,
  input logic [ptr_width_p-1:0] cptr_i,
  input logic [ptr_width_p-1:0] rptr_i
);

  commit_past_issue_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (commit_v_i && !clr_v_i) |-> (cptr_i != rptr_i))
    else $error("commit with nothing dequeued");

  yumi_without_valid_a: assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o_i)
    else $error("yumi while fe_queue_v_o low");

endmodule

// File: rtl/bp_be_fe_queue_ptr.sv
// Wrap-bit queue pointer: async reset to zero, load has priority over increment.
module bp_be_fe_queue_ptr #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  logic [width_p-1:0] ptr_r;

  // Pointer register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else if (load_i) begin
      ptr_r <= load_val_i;
    end else if (inc_i) begin
      ptr_r <= ptr_r + width_p'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_o = ptr_r;

endmodule

// File: rtl/bp_be_fe_queue_fifo.sv
// Speculative FE queue buffer with write, speculative-read and commit pointers.
// Optional same-cycle bypass on an empty read side: BP_BE_FE_QUEUE_BYPASS_EN.
module bp_be_fe_queue_fifo
  import bp_be_fe_queue_fifo_pkg::*;
#(
  parameter  int els_p        = bp_be_fe_queue_els_gp,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_and_o,
  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,
  input  logic                         commit_v_i,
  input  logic                         roll_v_i,
  input  logic                         clr_v_i,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam logic [ptr_width_lp-1:0] wrap_msb_lp = {1'b1, {(ptr_width_lp-1){1'b0}}};
  localparam logic [ptr_width_lp-1:0] one_lp      = ptr_width_lp'(1);

  logic [ptr_width_lp-1:0]      wptr_s, rptr_s, cptr_s;
  logic [ptr_width_lp-1:0]      wptr_n_s, cptr_n_s, rptr_load_val_s;
  logic                         enq_s, full_n_s, ready_r;
  logic [fe_queue_width_lp-1:0] mem_r [els_p];

  assign enq_s = fe_queue_v_i & ready_r;

  // Next write/commit pointers; clear collapses everything onto wptr
  always_comb begin
    wptr_n_s        = wptr_s;
    cptr_n_s        = cptr_s;
    rptr_load_val_s = cptr_s;
    if (clr_v_i) begin
      wptr_n_s        = wptr_s;
      cptr_n_s        = wptr_s;
      rptr_load_val_s = wptr_s;
    end else begin
      wptr_n_s        = enq_s ? (wptr_s + one_lp) : wptr_s;
      cptr_n_s        = commit_v_i ? (cptr_s + one_lp) : cptr_s;
      rptr_load_val_s = cptr_n_s;
    end
  end

  bp_be_fe_queue_ptr #(.width_p(ptr_width_lp)) wptr_u (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (enq_s),
    .load_i     (clr_v_i),
    .load_val_i (wptr_s),
    .ptr_o      (wptr_s)
  );

  bp_be_fe_queue_ptr #(.width_p(ptr_width_lp)) rptr_u (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (fe_queue_yumi_i),
    .load_i     (clr_v_i | roll_v_i),
    .load_val_i (rptr_load_val_s),
    .ptr_o      (rptr_s)
  );

  bp_be_fe_queue_ptr #(.width_p(ptr_width_lp)) cptr_u (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (commit_v_i),
    .load_i     (clr_v_i),
    .load_val_i (wptr_s),
    .ptr_o      (cptr_s)
  );

  // Packet storage; a dropped enqueue during clear never lands
  always_ff @(posedge clk_i) begin
    if (enq_s & ~clr_v_i) begin
      mem_r[wptr_s[ptr_width_lp-2:0]] <= fe_queue_i;
    end
  end

  assign full_n_s = ((wptr_n_s ^ cptr_n_s) == wrap_msb_lp);

  // Ready is held in a register so it never sees current-cycle inputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= ~full_n_s;
    end
  end

  assign fe_queue_ready_and_o = ready_r;
  assign empty_o              = (wptr_s == cptr_s);
  assign full_o               = ((wptr_s ^ cptr_s) == wrap_msb_lp);

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
  logic byp_s;
  assign byp_s        = (rptr_s == wptr_s) & enq_s & ~clr_v_i;
  assign fe_queue_o   = byp_s ? fe_queue_i : mem_r[rptr_s[ptr_width_lp-2:0]];
  assign fe_queue_v_o = (rptr_s != wptr_s) | byp_s;
`else
  assign fe_queue_o   = mem_r[rptr_s[ptr_width_lp-2:0]];
  assign fe_queue_v_o = (rptr_s != wptr_s);
`endif

  bp_be_fe_queue_fifo_chk #(.ptr_width_p(ptr_width_lp)) chk_u (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .commit_v_i (commit_v_i),
    .clr_v_i    (clr_v_i),
    .yumi_i     (fe_queue_yumi_i),
    .v_o_i      (fe_queue_v_o),
    .cptr_i     (cptr_s),
    .rptr_i     (rptr_s)
  );

endmodule

// File: tb/tb_bp_be_fe_queue_fifo.sv
// Directed scoreboard bench for bp_be_fe_queue_fifo (default build).
module tb_bp_be_fe_queue_fifo;
  import bp_be_fe_queue_fifo_pkg::*;

  localparam int W = fe_queue_width_lp;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic [W-1:0] fe_queue_i = '0;
  logic         fe_queue_v_i = 1'b0;
  logic         fe_queue_ready_and_o;
  logic [W-1:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i = 1'b0;
  logic         commit_v_i = 1'b0;
  logic         roll_v_i = 1'b0;
  logic         clr_v_i = 1'b0;
  logic         empty_o;
  logic         full_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  bp_be_fe_queue_fifo dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .fe_queue_i           (fe_queue_i),
    .fe_queue_v_i         (fe_queue_v_i),
    .fe_queue_ready_and_o (fe_queue_ready_and_o),
    .fe_queue_o           (fe_queue_o),
    .fe_queue_v_o         (fe_queue_v_o),
    .fe_queue_yumi_i      (fe_queue_yumi_i),
    .commit_v_i           (commit_v_i),
    .roll_v_i             (roll_v_i),
    .clr_v_i              (clr_v_i),
    .empty_o              (empty_o),
    .full_o               (full_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pkt(input int id);
    logic [W-1:0] p;
    logic [7:0]   b;
    b = id[7:0];
    p = '0;
    p[7:0]  = b;
    p[15:8] = ~b;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output packet must match the next expected one
  always @(negedge clk) begin
    if (!reset_i && fe_queue_v_o && fe_queue_yumi_i && !clr_v_i && !roll_v_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", fe_queue_o[15:0]);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (fe_queue_o !== e) begin
          errors++;
          $display("FAIL sb_data actual=%0h required=%0h", fe_queue_o[15:0], e[15:0]);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    commit_v_i      = 1'b0;
    roll_v_i        = 1'b0;
    clr_v_i         = 1'b0;
  endtask

  task automatic enq(input int id);
    fe_queue_v_i = 1'b1;
    fe_queue_i   = pkt(id);
    cycle();
  endtask

  task automatic deq(input int id);
    fe_queue_yumi_i = 1'b1;
    exp_q.push_back(pkt(id));
    cycle();
  endtask

  task automatic cmt();
    commit_v_i = 1'b1;
    cycle();
  endtask

  initial begin
    logic [W-1:0] t;
    int head, nxt;

    // reset state
    #2;
    chk("rst_v", 32'(fe_queue_v_o), 32'd0);
    chk("rst_ready", 32'(fe_queue_ready_and_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    chk("rel_ready_pre_edge", 32'(fe_queue_ready_and_o), 32'd0);
    cycle();
    chk("rel_ready", 32'(fe_queue_ready_and_o), 32'd1);
    chk("rel_empty", 32'(empty_o), 32'd1);

    // fill / drain
    for (int i = 0; i < 8; i++) begin
      enq(i);
      chk("fill_full", 32'(full_o), 32'(i == 7));
    end
    chk("fill_ready", 32'(fe_queue_ready_and_o), 32'd0);
    chk("fill_v", 32'(fe_queue_v_o), 32'd1);
    for (int i = 0; i < 8; i++) deq(i);
    chk("drain_v", 32'(fe_queue_v_o), 32'd0);
    chk("drain_uncommitted", 32'(empty_o), 32'd0);
    chk("drain_still_full", 32'(full_o), 32'd1);
    for (int i = 0; i < 8; i++) cmt();
    chk("commit_empty", 32'(empty_o), 32'd1);
    chk("commit_ready", 32'(fe_queue_ready_and_o), 32'd1);

    // roll-back
    for (int i = 0; i < 5; i++) enq(10 + i);
    deq(10); deq(11); deq(12);
    cmt();
    roll_v_i = 1'b1;
    cycle();
    t = pkt(11);
    chk("roll_v", 32'(fe_queue_v_o), 32'd1);
    chk("roll_data", 32'(fe_queue_o[15:0]), 32'(t[15:0]));
    for (int i = 11; i < 15; i++) deq(i);
    for (int i = 0; i < 4; i++) cmt();
    chk("roll_empty", 32'(empty_o), 32'd1);

    // commit + roll in the same cycle
    for (int i = 0; i < 5; i++) enq(20 + i);
    deq(20); deq(21); deq(22);
    commit_v_i = 1'b1;
    roll_v_i   = 1'b1;
    cycle();
    t = pkt(21);
    chk("cr_data", 32'(fe_queue_o[15:0]), 32'(t[15:0]));
    chk("cr_empty", 32'(empty_o), 32'd0);
    for (int i = 21; i < 25; i++) deq(i);
    for (int i = 0; i < 4; i++) cmt();
    chk("cr_drained", 32'(empty_o), 32'd1);

    // flush beats enqueue, yumi and commit
    for (int i = 0; i < 6; i++) enq(30 + i);
    deq(30); deq(31);
    clr_v_i         = 1'b1;
    fe_queue_v_i    = 1'b1;
    fe_queue_i      = pkt(99);
    fe_queue_yumi_i = 1'b1;
    commit_v_i      = 1'b1;
    cycle();
    chk("clr_empty", 32'(empty_o), 32'd1);
    chk("clr_v", 32'(fe_queue_v_o), 32'd0);
    chk("clr_ready", 32'(fe_queue_ready_and_o), 32'd1);
    chk("clr_full", 32'(full_o), 32'd0);
    cycle();
    chk("clr_drop_v", 32'(fe_queue_v_o), 32'd0);
    chk("clr_drop_empty", 32'(empty_o), 32'd1);

    // wrap: keep the queue full through 20 yumi/commit/enqueue triples
    for (int i = 0; i < 8; i++) enq(40 + i);
    chk("wrap_fill_full", 32'(full_o), 32'd1);
    head = 40;
    nxt  = 48;
    for (int k = 0; k < 20; k++) begin
      deq(head);
      head++;
      chk("wrap_full_after_yumi", 32'(full_o), 32'd1);
      cmt();
      chk("wrap_full_after_commit", 32'(full_o), 32'd0);
      chk("wrap_ready", 32'(fe_queue_ready_and_o), 32'd1);
      enq(nxt);
      nxt++;
      chk("wrap_full_after_enq", 32'(full_o), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      deq(head);
      head++;
    end
    for (int i = 0; i < 8; i++) cmt();
    chk("wrap_empty", 32'(empty_o), 32'd1);

    // asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) enq(80 + i);
    #3 reset_i = 1'b1;
    #1;
    chk("arst_v", 32'(fe_queue_v_o), 32'd0);
    chk("arst_empty", 32'(empty_o), 32'd1);
    chk("arst_full", 32'(full_o), 32'd0);
    chk("arst_ready", 32'(fe_queue_ready_and_o), 32'd0);
    #2 reset_i = 1'b0;
    chk("arst_rel_ready_pre_edge", 32'(fe_queue_ready_and_o), 32'd0);
    cycle();
    chk("arst_rel_ready", 32'(fe_queue_ready_and_o), 32'd1);
    chk("arst_rel_v", 32'(fe_queue_v_o), 32'd0);

    // one-cycle enqueue-to-valid latency
    fe_queue_v_i = 1'b1;
    fe_queue_i   = pkt(90);
    #1;
    chk("lat_v_same_cycle", 32'(fe_queue_v_o), 32'd0);
    cycle();
    t = pkt(90);
    chk("lat_v_next", 32'(fe_queue_v_o), 32'd1);
    chk("lat_data", 32'(fe_queue_o[15:0]), 32'(t[15:0]));
    deq(90);
    cmt();
    chk("lat_empty", 32'(empty_o), 32'd1);

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_fe_queue_fifo.md
Name: bp_be_fe_queue_fifo

Overview:
- Speculative FE queue buffer between the front end's fetch packet output and the BE scheduler's FE queue input.
- Holds fetch packets until commit so the BE can roll back issue to the oldest uncommitted packet without re-fetching.
- Supports a full flush on redirect.
- Three wrap-bit pointers: write (wptr), speculative read (rptr), commit (cptr).

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration; supplies fe_queue_width_lp through the core-if width macros.
- els_p, 8, queue depth; must be a power of two and at least 2.
- ptr_width_lp, $clog2(els_p)+1 (localparam), pointer width including the wrap bit.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- fe_queue_i  in  fe_queue_width_lp  fetch packet from FE.
- fe_queue_v_i  in  1  packet valid.
- fe_queue_ready_and_o  out  1  can accept (ready-and handshake).
- fe_queue_o  out  fe_queue_width_lp  packet at rptr, to scheduler.
- fe_queue_v_o  out  1  packet available.
- fe_queue_yumi_i  in  1  scheduler consumes packet; legal only when fe_queue_v_o is high.
- commit_v_i  in  1  retire the oldest dequeued packet.
- roll_v_i  in  1  rewind rptr to cptr.
- clr_v_i  in  1  flush all entries.
- empty_o  out  1  no entries between cptr and wptr.
- full_o  out  1  els_p entries held.

Interface rule (Already decided): one clock; reset is asynchronous and active-high; ports named clk_i and reset_i.

Behaviour:
- Storage and reads
  - Storage is an els_p-entry register array indexed by pointer low bits.
  - fe_queue_o is a combinational read at rptr.
- Reset
  - Asynchronous reset sets wptr = rptr = cptr = 0.
  - Outputs during reset: fe_queue_v_o = 0, fe_queue_ready_and_o = 0, empty_o = 1, full_o = 0.
  - Array contents are don't-care.
- Occupancy and flags
  - Occupancy is measured against the commit pointer: full when (wptr - cptr) == els_p, i.e. equal low bits and differing wrap bits.
  - empty_o = (wptr == cptr).
  - full_o is as defined above.
  - fe_queue_ready_and_o = ~full_o, registered-state only (no dependency on the current-cycle inputs).
  - fe_queue_v_o = (rptr != wptr).
- Pointer updates (all registered)
  - Enqueue when fe_queue_v_i & fe_queue_ready_and_o: write the array at wptr, wptr += 1.
  - Dequeue on fe_queue_yumi_i: rptr += 1.
  - Commit on commit_v_i: cptr += 1. Committing requires cptr != rptr; violating this is illegal and is flagged by an assertion.
- Same-cycle priority
  - clr_v_i beats everything: wptr, rptr and cptr all load the value of wptr. Any same-cycle enqueue is dropped, and any yumi, commit or roll is ignored.
  - roll_v_i: commit is applied first, then rptr <- next cptr. A same-cycle yumi is ignored.
  - Enqueue and dequeue in the same cycle are both performed.
  - Enqueue and commit while full: not possible, because ready is computed from registered state. The freed slot becomes usable the next cycle.
- Latency
  - Enqueue into an empty queue: fe_queue_v_o rises 1 cycle later.
  - Flush: empty the cycle after clr_v_i.
- Wrap-around
  - Pointers increment modulo 2^ptr_width_lp.
  - All comparisons use the full pointer, including the wrap bit.

Optional Feature:
- Macro: BP_BE_FE_QUEUE_BYPASS_EN.
- When defined:
  - While rptr == wptr and fe_queue_v_i & fe_queue_ready_and_o, fe_queue_o = fe_queue_i and fe_queue_v_o = 1 in the same cycle.
  - The entry is still written at wptr.
  - A same-cycle yumi advances both wptr and rptr.
  - clr_v_i suppresses the bypass.
- When undefined: 1-cycle latency as described under Behaviour. This is the default.

Decomposition:
- Packet type bp_fe_queue_s and fe_queue_width_lp come from the existing core-if declarations; no new package types are added.
- Add a constant bp_be_fe_queue_els_gp = 8 to bp_be_pkg for top-level sizing.
- One sub-module, bp_be_fe_queue_ptr: wrap-bit pointer register with async reset, inc_i and load_i/load_val_i (load has priority); instantiated three times.

Test Plan:
- Fill/drain:
  - Enqueue 8 packets (IDs 0..7) with yumi held low: full_o = 1 and ready = 0 after the 8th.
  - Yumi 8 times: IDs 0..7 come out in order.
  - Commit 8 times: empty_o = 1.
- Roll-back:
  - Enqueue 5, yumi 3, commit 1, then roll_v_i.
  - The next fe_queue_o is ID 1; the queue then re-issues 1, 2, 3, 4.
- Commit+roll same cycle:
  - After 3 yumis and 0 commits, assert commit_v_i and roll_v_i together.
  - rptr = cptr = 1; next output is ID 1.
- Flush:
  - With 6 entries held, assert clr_v_i together with fe_queue_v_i, yumi and commit.
  - Next cycle: empty_o = 1, fe_queue_v_o = 0, ready = 1; the enqueued packet is not visible.
- Wrap:
  - Run 20 enqueue/yumi/commit triples with depth 8.
  - Order is preserved across the wrap, and full_o is asserted exactly when wptr - cptr == 8.
- Async reset mid-operation:
  - Assert reset_i between clock edges with 4 entries held.
  - Outputs go immediately to fe_queue_v_o = 0, empty_o = 1, full_o = 0, ready = 0; ready = 1 on the first edge after release.
